ifu_pc_fetch: RTL and testbench

Owns the architectural PC register and runs the instruction-fetch handshake for the multi-cycle core. It presents `pc_cur` to the next-PC selector and latches that selector's `pc_next` result when the back end retires an instruction. It also issues one instruction-memory read per instruction and hands the fetched word, tagged with its PC, to decode over a valid/ready handshake.

---
 rtl/ifu_pc_fetch_if.sv | 29 ++
 rtl/ifu_pc_fetch.sv | 107 ++++++++++
 tb/tb_ifu_pc_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ifu_pc_fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the
// valid/ready hand-off of fetched instructions to decode.
interface ifu_pc_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready
  );
endinterface

// File: rtl/ifu_pc_fetch.sv
// Architectural PC register plus the one-instruction-at-a-time fetch
// sequencer for the multi-cycle core.
module ifu_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_next,
  input  logic                  pc_update,
  output logic [31:0]           pc_cur,
  ifu_pc_fetch_if.master        bus,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    EXEC = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_cur_q, pc_cur_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misaligned;

  assign misaligned = |pc_cur_q[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_cur_q     <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_cur_q     <= pc_cur_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_cur_d     = pc_cur_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    fetch_cnt_d  = fetch_cnt_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A misaligned PC never reaches memory; it is reported as a faulted fetch.
        if (misaligned) begin
          inst_d       = '0;
          inst_pc_d    = pc_cur_q;
          inst_fault_d = 1'b1;
          state_d      = HOLD;
        end else if (bus.imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d       = bus.imem_rsp_err ? '0 : bus.imem_rsp_data;
          inst_pc_d    = pc_cur_q;
          inst_fault_d = bus.imem_rsp_err;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (pc_update) begin
          pc_cur_d = pc_next;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake valids depend on registered state only.
  always_comb begin
    bus.imem_req_valid = (state_q == REQ) && !misaligned;
    bus.imem_req_addr  = pc_cur_q;
    bus.inst_valid     = (state_q == HOLD);
    bus.inst           = inst_q;
    bus.inst_pc        = inst_pc_q;
    bus.inst_fault     = inst_fault_q;
    pc_cur             = pc_cur_q;
    fetch_cnt          = fetch_cnt_q;
  end

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed bench for ifu_pc_fetch: per-cycle vector table plus reset-mid-fetch
// and counter-wrap sequences.
module tb_ifu_pc_fetch;

  localparam logic [31:0] P0   = 32'h8000_0000;
  localparam logic [31:0] P4   = 32'h8000_0004;
  localparam logic [31:0] P100 = 32'h8000_0100;
  localparam logic [31:0] P102 = 32'h8000_0102;
  localparam logic [31:0] P200 = 32'h8000_0200;
  localparam logic [31:0] I1   = 32'h0000_0013;
  localparam logic [31:0] I2   = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        pc_update;
  logic [31:0] pc_cur;
  logic [31:0] fetch_cnt;

  ifu_pc_fetch_if bus();

  ifu_pc_fetch #(.RESET_PC(P0)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_next   (pc_next),
    .pc_update (pc_update),
    .pc_cur    (pc_cur),
    .bus       (bus.master),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic        rerr;
    logic        irdy;
    logic        upd;
    logic [31:0] pnext;
    logic        e_rv;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_f;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_acc = 0;

  function automatic vec_t mk(logic rdy, logic rsp, logic [31:0] rdata, logic rerr,
                              logic irdy, logic upd, logic [31:0] pnext,
                              logic e_rv, logic e_iv, logic [31:0] e_inst,
                              logic [31:0] e_ipc, logic e_f, logic [31:0] e_pc,
                              logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.rerr = rerr;
    v.irdy = irdy; v.upd = upd; v.pnext = pnext;
    v.e_rv = e_rv; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    v.e_f = e_f; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] rdata,
                       input logic rerr, input logic irdy, input logic upd,
                       input logic [31:0] pnext);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;
    bus.imem_rsp_err   = rerr;
    bus.inst_ready     = irdy;
    pc_update          = upd;
    pc_next            = pnext;
  endtask

  task automatic chk_all(input string tag, input logic rv, input logic iv,
                         input logic [31:0] inst, input logic [31:0] ipc, input logic f,
                         input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, ".req_valid"},  {31'd0, bus.imem_req_valid}, {31'd0, rv});
    chk({tag, ".req_addr"},   bus.imem_req_addr, pc);
    chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, iv});
    chk({tag, ".inst"},       bus.inst, inst);
    chk({tag, ".inst_pc"},    bus.inst_pc, ipc);
    chk({tag, ".inst_fault"}, {31'd0, bus.inst_fault}, {31'd0, f});
    chk({tag, ".pc_cur"},     pc_cur, pc);
    chk({tag, ".fetch_cnt"},  fetch_cnt, cnt);
  endtask

  initial begin
    // boot, fetch, backpressure, ignored pc_update, redirect, bus error, misalignment
    tbl.push_back(mk(1,0,0,0,0,0,0,             0,0,0,   0,   0,P0,  0));
    tbl.push_back(mk(1,0,0,0,0,0,0,             1,0,0,   0,   0,P0,  0));
    tbl.push_back(mk(1,1,I1,0,0,0,0,            0,0,0,   0,   0,P0,  0));
    tbl.push_back(mk(0,0,0,0,1,0,0,             0,1,I1,  P0,  0,P0,  0));
    tbl.push_back(mk(0,0,0,0,0,1,P4,            0,0,I1,  P0,  0,P0,  1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,0,0,0,           1,0,I1,  P0,  0,P4,  1));
    tbl.push_back(mk(1,0,0,0,0,0,0,             1,0,I1,  P0,  0,P4,  1));
    tbl.push_back(mk(1,0,0,0,0,1,32'hDEAD_0000, 0,0,I1,  P0,  0,P4,  1));
    tbl.push_back(mk(0,1,I2,0,0,0,0,            0,0,I1,  P0,  0,P4,  1));
    tbl.push_back(mk(0,0,0,0,0,1,32'h1234_5678, 0,1,I2,  P4,  0,P4,  1));
    tbl.push_back(mk(0,0,0,0,0,0,0,             0,1,I2,  P4,  0,P4,  1));
    tbl.push_back(mk(0,0,0,0,0,0,0,             0,1,I2,  P4,  0,P4,  1));
    tbl.push_back(mk(0,0,0,0,1,0,0,             0,1,I2,  P4,  0,P4,  1));
    tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,I2,  P4,  0,P4,  2));
    tbl.push_back(mk(0,0,0,0,0,1,P100,          0,0,I2,  P4,  0,P4,  2));
    tbl.push_back(mk(1,0,0,0,0,0,0,             1,0,I2,  P4,  0,P100,2));
    tbl.push_back(mk(0,1,32'hFFFF_FFFF,1,0,0,0, 0,0,I2,  P4,  0,P100,2));
    tbl.push_back(mk(0,0,0,0,1,0,0,             0,1,0,   P100,1,P100,2));
    tbl.push_back(mk(0,0,0,0,0,1,P102,          0,0,0,   P100,1,P100,3));
    tbl.push_back(mk(1,1,32'hAAAA_5555,0,0,0,0, 0,0,0,   P100,1,P102,3));
    tbl.push_back(mk(0,0,0,0,1,0,0,             0,1,0,   P102,1,P102,3));
    tbl.push_back(mk(0,0,0,0,0,1,P200,          0,0,0,   P102,1,P102,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,             1,0,0,   P102,1,P200,4));

    drive(0,0,0,0,0,0,0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 0,0,0,0,0,P0,0);

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].rerr,
            tbl[i].irdy, tbl[i].upd, tbl[i].pnext);
      #1;
      if (bus.imem_req_valid && tbl[i].rdy) n_acc++;
      chk_all($sformatf("v%0d", i), tbl[i].e_rv, tbl[i].e_iv, tbl[i].e_inst,
              tbl[i].e_ipc, tbl[i].e_f, tbl[i].e_pc, tbl[i].e_cnt);
    end
    chk("accepted_requests", n_acc, 3);

    // reset while a read is outstanding, then a stale response after release
    @(negedge clk); drive(1,0,0,0,0,0,0); #1;
    chk("mr.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    @(negedge clk); drive(0,0,0,0,0,0,0); #1;
    chk("mr.wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    rst = 1'b1; #1;
    chk_all("mr.in_reset", 0,0,0,0,0,P0,0);
    @(negedge clk); rst = 1'b0; drive(0,1,32'hBAAD_F00D,0,0,0,0); #1;
    chk_all("mr.idle", 0,0,0,0,0,P0,0);
    @(negedge clk); drive(0,1,32'hBAAD_F00D,0,0,0,0); #1;
    chk_all("mr.req_stale", 1,0,0,0,0,P0,0);
    @(negedge clk); drive(1,0,0,0,0,0,0); #1;
    chk_all("mr.req", 1,0,0,0,0,P0,0);
    @(negedge clk); drive(0,1,32'h0050_0093,0,0,0,0); #1;
    chk_all("mr.wait", 0,0,0,0,0,P0,0);
    @(negedge clk); drive(0,0,0,0,1,0,0); #1;
    chk_all("mr.hold", 0,1,32'h0050_0093,P0,0,P0,0);
    @(negedge clk); drive(0,0,0,0,0,0,0); #1;
    chk_all("mr.exec", 0,0,32'h0050_0093,P0,0,P0,1);

    // counter wrap: preload the count while idling in EXEC
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.fetch_cnt_q;
    @(negedge clk); drive(0,0,0,0,0,1,P0); #1;
    chk("wrap.preload", fetch_cnt, 32'hFFFF_FFFF);
    @(negedge clk); drive(1,0,0,0,0,0,0);
    @(negedge clk); drive(0,1,I1,0,0,0,0);
    @(negedge clk); drive(0,0,0,0,1,0,0); #1;
    chk_all("wrap.hold", 0,1,I1,P0,0,P0,32'hFFFF_FFFF);
    @(negedge clk); drive(0,0,0,0,0,0,0); #1;
    chk_all("wrap.exec", 0,0,I1,P0,0,P0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
